// File: rtl/sequenceur_adresse.sv
// Sample-RAM address sequencer: record, step-back review and playback; SEQADR_WRAP_EN makes step-back wrap from 0 to AdMax.
// WrEn/RdEn one cycle after their strobe; no backpressure, a Tick landing on an active RdEn is dropped.
module sequenceur_adresse #(
  parameter int POLARITY_RA = 1,
  parameter int MODE        = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Mode,
  input  logic       SampleValid,
  input  logic       RetourArriere,
  input  logic       Lecture,
  input  logic       Tick,
  output logic [6:0] Adresse,
  output logic       WrEn,
  output logic       RdEn,
  output logic [6:0] AdMax,
  output logic       Plein,
  output logic [1:0] Etat
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECORD = 2'b01,
    REVIEW = 2'b10,
    PLAY   = 2'b11
  } etat_t;

  etat_t      etatQ;
  logic [7:0] nbEch;
  logic       raPrev;
  logic       edgeRa;
  logic       pm;
  logic       raPol;
  logic       raActive;

  assign pm       = (MODE != 0) ? Mode : ~Mode;
  assign raPol    = (POLARITY_RA != 0) ? RetourArriere : ~RetourArriere;
  assign raActive = raPol & ~raPrev;

  // nbEch never exceeds 128, so bit 7 alone flags a full memory
  assign Plein = nbEch[7];
  assign Etat  = etatQ;

  function automatic logic [6:0] stepBack(input logic [6:0] a, input logic [6:0] m);
`ifdef SEQADR_WRAP_EN
    return (a == 7'd0) ? m : a - 7'd1;
`else
    return (a == 7'd0) ? 7'd0 : a - 7'd1;
`endif
  endfunction

  always_ff @(posedge Clk) begin
    if (Reset) begin
      etatQ   <= IDLE;
      Adresse <= 7'd0;
      AdMax   <= 7'd0;
      nbEch   <= 8'd0;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      raPrev  <= 1'b0;
      edgeRa  <= 1'b0;
    end else begin
      raPrev <= raPol;
      edgeRa <= raActive;
      WrEn   <= 1'b0;
      RdEn   <= 1'b0;
      case (etatQ)
        IDLE: begin
          if (pm) begin
            etatQ <= RECORD;
            nbEch <= 8'd0;
            AdMax <= 7'd0;
          end else if (nbEch != 8'd0) begin
            etatQ   <= REVIEW;
            Adresse <= AdMax;
          end
        end
        RECORD: begin
          if (!pm) begin
            if (nbEch != 8'd0) begin
              etatQ   <= REVIEW;
              Adresse <= AdMax;
            end else begin
              etatQ <= IDLE;
            end
          end else if (SampleValid && !Plein) begin
            WrEn    <= 1'b1;
            Adresse <= nbEch[6:0];
            AdMax   <= nbEch[6:0];
            nbEch   <= nbEch + 8'd1;
          end
        end
        REVIEW: begin
          if (pm) begin
            etatQ <= RECORD;
            nbEch <= 8'd0;
            AdMax <= 7'd0;
          end else if (Lecture) begin
            etatQ <= PLAY;
          end else if (edgeRa) begin
            Adresse <= stepBack(Adresse, AdMax);
          end
        end
        PLAY: begin
          if (pm) begin
            etatQ <= RECORD;
            nbEch <= 8'd0;
            AdMax <= 7'd0;
          end else if (RdEn) begin
            // close of the read cycle: advance, or park on the last sample
            if (Adresse < AdMax) begin
              Adresse <= Adresse + 7'd1;
            end else begin
              etatQ <= REVIEW;
            end
          end else if (Tick) begin
            RdEn <= 1'b1;
          end
        end
        default: etatQ <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sequenceur_adresse.md
# sequenceur_adresse

- Clocked controller that sequences the 128-word sample memory address: write addresses while recording, step-back and playback addresses while reviewing.
- Tracks how many samples were captured, the highest written address (`AdMax`) and the full condition.
- Sits between the user controls (`Mode`, `RetourArriere`, `Lecture`) and the sample RAM, and feeds `AdMax` to the address-management logic.

## Interface
Parameters:
- `POLARITY_RA`, default 1: `RetourArriere` active edge; 1 = rising, 0 = falling.
- `MODE`, default 1: `Mode` polarity; 1 = `Mode` high means record/normal, 0 = inverted.

Ports:
- `Clk` input, 1: single system clock, all logic on rising edge.
- `Reset` input, 1: synchronous, active-high.
- `Mode` input, 1: after polarity, 1 = record (normal), 0 = review. Synchronous, debounced upstream.
- `SampleValid` input, 1: one-cycle strobe, a new sample is present to store.
- `RetourArriere` input, 1: step-back button level. Synchronous, debounced upstream.
- `Lecture` input, 1: one-cycle strobe, start playback from the current address.
- `Tick` input, 1: playback rate strobe, at most one every 2 cycles.
- `Adresse` output, 7: RAM address (registered).
- `WrEn` output, 1: one-cycle RAM write enable.
- `RdEn` output, 1: one-cycle RAM read enable.
- `AdMax` output, 7: last written address.
- `Plein` output, 1: all 128 words written.
- `Etat` output, 2: FSM state; 00 IDLE, 01 RECORD, 10 REVIEW, 11 PLAY.

## Operation
- Internal 8-bit counter `NbEch` (0..128) holds the number of stored samples. `Plein` = (`NbEch` == 128).
- `pm` is `Mode` after polarity; `edge` is the active `RetourArriere` edge (after polarity) from a one-register edge detector.
- Reset values: `Etat` IDLE, `Adresse` 0, `AdMax` 0, `NbEch` 0, `WrEn` 0, `RdEn` 0, `Plein` 0, edge register 0.
- Priority in every state: `Reset` > `pm` change > `Lecture` > `edge` > `Tick`/`SampleValid`.

States:
- IDLE:
  - `pm`=1: go to RECORD, clear `NbEch` and `AdMax`.
  - `pm`=0 and `NbEch`>0: go to REVIEW, `Adresse`←`AdMax`.
  - Otherwise stay in IDLE.
- RECORD:
  - On `SampleValid` with `Plein`=0: `WrEn`←1, `Adresse`←`NbEch[6:0]`, `AdMax`←`NbEch[6:0]`, `NbEch`+1.
  - On `SampleValid` with `Plein`=1: ignored, no `WrEn`.
  - `pm`=0: go to REVIEW with `Adresse`←`AdMax` if `NbEch`>0, else go to IDLE.
- REVIEW:
  - On `edge`: `Adresse`−1, saturating at 0 (see Configuration).
  - On `Lecture`: go to PLAY. If `edge` coincides with `Lecture`, the edge is discarded.
  - `pm`=1: go to RECORD, clear `NbEch`, `AdMax` and `Plein`. This starts a new recording.
- PLAY:
  - On `Tick`: `RdEn`←1 for one cycle at the current `Adresse`.
  - On the edge closing that `RdEn` cycle: `Adresse`+1 if `Adresse`<`AdMax`; otherwise stay at `AdMax` and return to REVIEW.
  - A `Tick` arriving while `RdEn`=1 is ignored.
  - `edge` is ignored in PLAY.
  - `pm`=1: go to RECORD as from REVIEW.
- `Reset` mid-operation: all registers return to reset values on the next edge; an in-flight `WrEn`/`RdEn` pulse is cut.

## Timing
- `SampleValid` sampled at edge k gives `WrEn`=1 during cycle k+1 with `Adresse` = write address. Back-to-back strobes give consecutive writes at n, n+1, …
- `RetourArriere` transition sampled at edge k gives `Adresse` updated after edge k+1 (one cycle for the edge detector).
- `Tick` at edge k gives `RdEn` during cycle k+1; `Adresse` advances at edge k+1.
- Mode change takes effect on the first edge after `pm` toggles; `Etat` is updated on that same edge.
- `WrEn` and `RdEn` are never high simultaneously, and each is never high for two cycles.

## Configuration
- `SEQADR_WRAP_EN` defined: in REVIEW, `edge` at `Adresse`=0 wraps to `AdMax`.
- Undefined: `Adresse` saturates at 0 and extra back-steps are no-ops.
- No other behaviour differs between the two builds.

## Test plan
- Reset, then `pm`=1, 3 `SampleValid` pulses → `WrEn` pulses at `Adresse` 0, 1, 2; `AdMax`=2; `Etat`=01.
- 130 `SampleValid` in RECORD → 128 writes at 0..127, `Plein`=1 after the 128th, pulses 129–130 produce no `WrEn`.
- Record 5 samples, `pm`→0, 3 `RetourArriere` rising edges → `Adresse` 4, 3, 2, 1. Then 2 more edges → `Adresse` 0, 0 without the macro; 0, 4 with `SEQADR_WRAP_EN`.
- From REVIEW at `Adresse`=2, `AdMax`=4, `Lecture` then 4 `Tick`s → `RdEn` at 2, 3, 4, then `Etat` back to 10 with `Adresse`=4; the 4th `Tick` produces no `RdEn`.
- `Lecture` and `RetourArriere` edge in the same cycle → PLAY entered, `Adresse` unchanged.
- `Reset` asserted during PLAY with `RdEn`=1 → next cycle all outputs 0, `Etat`=00.
